// File: rtl/soc_evt_tx_pkg.sv
// Shared types and helpers for the SoC-peripheral event transmitter.
package soc_evt_tx_pkg;

  // Wide enough for any practical source count plus the overflow slot.
  localparam int SLOT_W = 16;

  typedef logic [SLOT_W-1:0] slot_idx_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } tx_state_e;

  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

  function automatic int evt_id(input int base, input slot_idx_t idx);
    return base + int'(idx);
  endfunction

endpackage

// File: rtl/soc_evt_tx_rr_arb.sv
// Round-robin arbiter: grants the first request strictly after the last grant.
module soc_evt_tx_rr_arb
  import soc_evt_tx_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] req_i,
  input  logic         gnt_en_i,
  output logic [N-1:0] gnt_o,
  output slot_idx_t    idx_o,
  output logic         any_o
);

  slot_idx_t last_q;
  slot_idx_t hi_idx, lo_idx;
  logic      hi_found;

  // Scan downward so the lowest eligible index wins; "hi" candidates sit
  // after the pointer, "lo" is the wrapped fallback.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req_i[j]) begin
        lo_idx = slot_idx_t'(j);
        if (j > int'(last_q)) begin
          hi_idx   = slot_idx_t'(j);
          hi_found = 1'b1;
        end
      end
    end
  end

  assign any_o = |req_i;
  assign idx_o = hi_found ? hi_idx : lo_idx;

  always_comb begin
    gnt_o = '0;
    for (int j = 0; j < N; j++)
      gnt_o[j] = any_o && (slot_idx_t'(j) == idx_o);
  end

  // Reset to the last slot so slot 0 has top priority.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                 last_q <= slot_idx_t'(N - 1);
    else if (gnt_en_i && any_o)  last_q <= idx_o;
  end

endmodule

// File: rtl/soc_periph_evt_tx.sv
// SoC-side event transmitter toward the cluster SoC event FIFO.
// Optional overflow event slot: define SOC_EVT_TX_OVFL_EVT_EN.
module soc_periph_evt_tx
  import soc_evt_tx_pkg::*;
#(
  parameter int NB_SRC     = 32,
  parameter int EVNT_WIDTH = 8,
  parameter int CNT_W      = 2,
  parameter int ID_BASE    = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NB_SRC-1:0]     evt_i,
  input  logic [NB_SRC-1:0]     evt_mask_i,
  input  logic [NB_SRC-1:0]     ovfl_clr_i,
  output logic [NB_SRC-1:0]     ovfl_o,
  output logic                  evt_valid_o,
  input  logic                  evt_ready_i,
  output logic [EVNT_WIDTH-1:0] evt_data_o,
  output logic                  busy_o
);

`ifdef SOC_EVT_TX_OVFL_EVT_EN
  localparam int NSLOT = NB_SRC + 1;
`else
  localparam int NSLOT = NB_SRC;
`endif
  localparam logic [CNT_W-1:0] CMAX = CNT_W'(cnt_max(CNT_W));

  logic [NB_SRC-1:0][CNT_W-1:0] cnt_q;
  logic [NB_SRC-1:0]            inc, dec, pend, ovf_set;
  logic [NSLOT-1:0]             req, gnt;
  slot_idx_t                    gnt_idx;
  logic                         any_req, load_en, gnt_en;
  logic [EVNT_WIDTH-1:0]        id_next;
  tx_state_e                    state_q, state_d;

  assign load_en = (state_q == ST_IDLE) | evt_ready_i;
  assign gnt_en  = load_en & any_req;
  assign inc     = evt_i & evt_mask_i;
  assign dec     = gnt[NB_SRC-1:0] & {NB_SRC{load_en}};

  always_comb begin
    pend    = '0;
    ovf_set = '0;
    for (int i = 0; i < NB_SRC; i++) begin
      pend[i]    = |cnt_q[i];
      ovf_set[i] = inc[i] & ~dec[i] & (cnt_q[i] == CMAX);
    end
  end

  // Simultaneous inc and dec cancel; a saturated count holds on overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      ovfl_o <= '0;
    end else begin
      for (int i = 0; i < NB_SRC; i++) begin
        if (inc[i] && !dec[i] && cnt_q[i] != CMAX) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        else if (!inc[i] && dec[i])                cnt_q[i] <= cnt_q[i] - CNT_W'(1);
        if (ovf_set[i])         ovfl_o[i] <= 1'b1;
        else if (ovfl_clr_i[i]) ovfl_o[i] <= 1'b0;
      end
    end
  end

`ifdef SOC_EVT_TX_OVFL_EVT_EN
  logic ovfl_evt_q;

  // A fresh overflow in the granting cycle keeps the flag set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ovfl_evt_q <= 1'b0;
    else         ovfl_evt_q <= (|ovf_set) | (ovfl_evt_q & ~(gnt[NB_SRC] & load_en));
  end

  assign req    = {ovfl_evt_q, pend};
  assign busy_o = (|pend) | ovfl_evt_q | evt_valid_o;
`else
  assign req    = pend;
  assign busy_o = (|pend) | evt_valid_o;
`endif

  soc_evt_tx_rr_arb #(
    .N (NSLOT)
  ) u_arb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (req),
    .gnt_en_i (gnt_en),
    .gnt_o    (gnt),
    .idx_o    (gnt_idx),
    .any_o    (any_req)
  );

  assign id_next = EVNT_WIDTH'(evt_id(ID_BASE, gnt_idx));

  always_comb begin
    state_d = state_q;
    if (load_en) state_d = any_req ? ST_HOLD : ST_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Data holds its last ID when the register drains empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     evt_data_o <= '0;
    else if (gnt_en) evt_data_o <= id_next;
  end

  assign evt_valid_o = (state_q == ST_HOLD);

endmodule

// File: tb/tb_soc_periph_evt_tx.sv
// Directed bench for soc_periph_evt_tx: vector table plus multi-cycle sequences.
module tb_soc_periph_evt_tx;

`ifdef SOC_EVT_TX_OVFL_EVT_EN
  localparam int ID_BASE = 16;
  localparam bit OVF_EVT = 1'b1;
`else
  localparam int ID_BASE = 0;
  localparam bit OVF_EVT = 1'b0;
`endif
  localparam int NB_SRC = 32;
  localparam logic [31:0] ALL = 32'hFFFF_FFFF;

  typedef struct {
    bit          rst;
    logic [31:0] evt;
    logic [31:0] mask;
    bit          rdy;
    logic [31:0] clr;
    bit          v;
    logic [7:0]  d;
    bit          busy;
    logic [31:0] ovfl;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] evt = '0, mask = ALL, clr = '0;
  logic        rdy = 1'b1;
  logic [31:0] ovfl;
  logic        valid, busy;
  logic [7:0]  data;

  int   total = 0, bad = 0;
  vec_t tbl[$];
  int   exp_q[$];

  always #5 clk = ~clk;

  soc_periph_evt_tx #(
    .NB_SRC(NB_SRC), .EVNT_WIDTH(8), .CNT_W(2), .ID_BASE(ID_BASE)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .evt_i(evt), .evt_mask_i(mask),
    .ovfl_clr_i(clr), .ovfl_o(ovfl), .evt_valid_o(valid),
    .evt_ready_i(rdy), .evt_data_o(data), .busy_o(busy)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endfunction

  task automatic add(input bit r, input logic [31:0] e, input logic [31:0] m, input bit rd,
                     input logic [31:0] c, input bit v, input int d, input bit b,
                     input logic [31:0] o);
    vec_t x;
    x.rst = r; x.evt = e; x.mask = m; x.rdy = rd; x.clr = c;
    x.v = v; x.d = 8'(d); x.busy = b; x.ovfl = o;
    tbl.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    evt = '0; mask = ALL; clr = '0; rdy = 1'b1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  // Accept the event already held, then expect exp_q loads, then empty.
  task automatic drain(input string nm);
    evt = '0; clr = '0; rdy = 1'b1;
    foreach (exp_q[k]) begin
      step();
      chk($sformatf("%s v%0d", nm, k), 32'(valid), 32'd1);
      chk($sformatf("%s d%0d", nm, k), 32'(data), 32'(exp_q[k]));
    end
    step();
    chk({nm, " empty"}, 32'(valid), 32'd0);
    chk({nm, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // Single pulse on source 5
    add(0, 32'h20, ALL, 1, 0, 0, 0, 1, 0);
    add(0, 0,      ALL, 1, 0, 1, ID_BASE + 5, 1, 0);
    add(0, 0,      ALL, 1, 0, 0, ID_BASE + 5, 0, 0);
    // Round-robin over 3/7, then 7/9 with pointer at 7
    add(1, 32'h88,  ALL, 1, 0, 0, 0, 1, 0);
    add(0, 0,       ALL, 1, 0, 1, ID_BASE + 3, 1, 0);
    add(0, 0,       ALL, 1, 0, 1, ID_BASE + 7, 1, 0);
    add(0, 32'h88,  ALL, 1, 0, 0, ID_BASE + 7, 1, 0);
    add(0, 0,       ALL, 1, 0, 1, ID_BASE + 3, 1, 0);
    add(0, 0,       ALL, 1, 0, 1, ID_BASE + 7, 1, 0);
    add(0, 32'h280, ALL, 1, 0, 0, ID_BASE + 7, 1, 0);
    add(0, 0,       ALL, 1, 0, 1, ID_BASE + 9, 1, 0);
    add(0, 0,       ALL, 1, 0, 1, ID_BASE + 7, 1, 0);
    add(0, 0,       ALL, 1, 0, 0, ID_BASE + 7, 0, 0);
    // Masked source 1 dropped; source 6 drains after being masked
    add(1, 32'h2,  32'hFFFF_FFFD, 1, 0, 0, 0, 0, 0);
    add(0, 0,      ALL,           1, 0, 0, 0, 0, 0);
    add(0, 32'h40, ALL,           0, 0, 0, 0, 1, 0);
    add(0, 32'h40, ALL,           0, 0, 1, ID_BASE + 6, 1, 0);
    add(0, 32'h40, ALL,           0, 0, 1, ID_BASE + 6, 1, 0);
    add(0, 32'h40, 32'hFFFF_FFBF, 1, 0, 1, ID_BASE + 6, 1, 0);
    add(0, 0,      32'hFFFF_FFBF, 1, 0, 1, ID_BASE + 6, 1, 0);
    add(0, 0,      32'hFFFF_FFBF, 1, 0, 0, ID_BASE + 6, 0, 0);

    // Reset state while held in reset
    #2;
    chk("rst valid", 32'(valid), 0);
    chk("rst data", 32'(data), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst ovfl", ovfl, 0);
    #2 rst_n = 1'b1;
    step();

    foreach (tbl[r]) begin
      if (tbl[r].rst) do_reset();
      evt = tbl[r].evt; mask = tbl[r].mask; rdy = tbl[r].rdy; clr = tbl[r].clr;
      step();
      chk($sformatf("row%0d valid", r), 32'(valid), 32'(tbl[r].v));
      chk($sformatf("row%0d data", r), 32'(data), 32'(tbl[r].d));
      chk($sformatf("row%0d busy", r), 32'(busy), 32'(tbl[r].busy));
      chk($sformatf("row%0d ovfl", r), ovfl, tbl[r].ovfl);
    end

    // Five pulses on source 2 under backpressure; set beats clear on the 5th
    do_reset();
    rdy = 1'b0;
    for (int p = 1; p <= 5; p++) begin
      evt = 32'h4;
      clr = (p == 5) ? 32'h4 : 32'h0;
      step();
      if (p == 1) chk("ovf p1 valid", 32'(valid), 0);
      if (p == 2) chk("ovf p2 data", 32'(data), 32'(ID_BASE + 2));
      if (p == 4) chk("ovf p4 ovfl", ovfl, 0);
    end
    chk("ovf set", ovfl, 32'h4);
    exp_q = {};
    if (OVF_EVT) exp_q.push_back(ID_BASE + NB_SRC);
    repeat (3) exp_q.push_back(ID_BASE + 2);
    drain("ovf drain");
    chk("ovf sticky", ovfl, 32'h4);
    clr = 32'h4;
    step();
    chk("ovf clr", ovfl, 0);
    clr = 32'h0;

    // Ten cycles of backpressure on a held event
    do_reset();
    rdy = 1'b0;
    evt = 32'h10;
    step();
    evt = '0;
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("hold%0d valid", c), 32'(valid), 1);
      chk($sformatf("hold%0d data", c), 32'(data), 32'(ID_BASE + 4));
    end
    rdy = 1'b1;
    step();
    chk("hold release valid", 32'(valid), 0);
    chk("hold release busy", 32'(busy), 0);

    // Overflow on source 0, slot after it is the overflow event if present
    do_reset();
    rdy = 1'b0;
    repeat (5) begin evt = 32'h1; step(); end
    chk("src0 ovfl", ovfl, 32'h1);
    exp_q = {};
    if (OVF_EVT) exp_q.push_back(ID_BASE + NB_SRC);
    repeat (3) exp_q.push_back(ID_BASE);
    drain("src0 drain");

    // Asynchronous reset mid-burst
    rdy = 1'b0;
    repeat (5) begin evt = 32'h7; step(); end
    chk("burst valid", 32'(valid), 1);
    chk("burst ovfl", ovfl, 32'h7);
    #2 rst_n = 1'b0;
    #1;
    chk("arst valid", 32'(valid), 0);
    chk("arst busy", 32'(busy), 0);
    chk("arst ovfl", ovfl, 0);
    chk("arst data", 32'(data), 0);
    evt = '0; rdy = 1'b1;
    #1 rst_n = 1'b1;
    step();
    chk("post arst valid", 32'(valid), 0);
    chk("post arst busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
